rv_timer: RTL and testbench



---
 rtl/rv_timer_pkg.sv | 41 ++++
 rtl/rv_timer_prescaler.sv | 37 +++
 rtl/rv_timer.sv | 173 +++++++++++++++++
 tb/tb_rv_timer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_timer_pkg.sv
// Shared definitions for the rv_timer block: register offsets, control bit
// positions, the register-select enum and a byte-lane merge helper.
package rv_timer_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    // Byte offsets of the timer registers inside the 32-byte window
    localparam logic [4:0] TMR_CTRL   = 5'h00;
    localparam logic [4:0] TMR_STAT   = 5'h04;
    localparam logic [4:0] TMR_PERIOD = 5'h08;
    localparam logic [4:0] TMR_COUNT  = 5'h0C;
    localparam logic [4:0] TMR_PRESC  = 5'h10;
    localparam logic [4:0] TMR_MTIME  = 5'h14;
    localparam logic [4:0] TMR_RSV6   = 5'h18;
    localparam logic [4:0] TMR_RSV7   = 5'h1C;

    // CTRL and STAT bit indices
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_EXP  = 0;

    // Word select taken from adr[4:2]
    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_STAT   = 3'd1,
        REG_PERIOD = 3'd2,
        REG_COUNT  = 3'd3,
        REG_PRESC  = 3'd4,
        REG_MTIME  = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } tmr_reg_e;

    // Replace only the bytes selected by the expanded write mask
    function automatic u32_t lane_merge(input u32_t old_v, input u32_t new_v, input u32_t mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/rv_timer_prescaler.sv
// Prescaler for rv_timer: counts 0..presc while enabled and emits a one-cycle
// tick on the compare match. Held at zero while disabled or when cleared.
module rv_timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_reg;
    logic [PRESC_W-1:0] pcnt_next;

    // The tick uses the current compare value; a PRESC write only restarts the count
    assign tick = en & (pcnt_reg == presc);

    // Next prescaler count: restart on clear, disable or wrap
    always_comb begin
        pcnt_next = pcnt_reg + 1'b1;
        if (clr || !en || tick) begin
            pcnt_next = '0;
        end
    end

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end

endmodule

// File: rtl/rv_timer.sv
// rv_timer: memory-mapped interval timer with a prescaled 32-bit down-counter
// (one-shot or auto-reload), a sticky expiry flag with level interrupt, and a
// free-running 32-bit cycle counter (MTIME).
module rv_timer
    import rv_timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  adr,
    input  logic        cs,
    input  logic        rdy,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] dw,
    output logic [31:0] dr,
    output logic        irq
);

    // Architectural state
    logic               en_reg,     en_next;
    logic               auto_reg,   auto_next;
    logic               ie_reg,     ie_next;
    logic               exp_reg,    exp_next;
    logic [31:0]        period_reg, period_next;
    logic [31:0]        count_reg,  count_next;
    logic [PRESC_W-1:0] presc_reg,  presc_next;
    logic [31:0]        mtime_reg;

    // Bus decode
    tmr_reg_e    sel;
    logic        wr_en;
    logic        wr_ctrl, wr_stat, wr_period, wr_count, wr_presc;
    logic [31:0] wmask;
    logic [31:0] presc_ext;
    logic [31:0] presc_merge;
    logic [31:0] rd_data;

    // Counter events
    logic tick;
    logic expire;

    // Byte offset bits never select anything; the timer is word-addressed
    logic unused_bits;
    assign unused_bits = ^{adr[1:0], presc_merge};

    // Expand per-lane write enables into a 32-bit mask
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[gi*8 +: 8] = {8{we[gi]}};
        end
    endgenerate

    assign sel       = tmr_reg_e'(adr[4:2]);
    assign wr_en     = cs & rdy & (we != 4'b0000);
    assign wr_ctrl   = wr_en & (sel == REG_CTRL);
    assign wr_stat   = wr_en & (sel == REG_STAT);
    assign wr_period = wr_en & (sel == REG_PERIOD);
    assign wr_count  = wr_en & (sel == REG_COUNT);
    assign wr_presc  = wr_en & (sel == REG_PRESC);

    assign presc_ext   = 32'(presc_reg);
    assign presc_merge = lane_merge(presc_ext, dw, wmask);

    rv_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en_reg),
        .presc (presc_reg),
        .clr   (wr_presc),
        .tick  (tick)
    );

    assign expire = tick & (count_reg == 32'd0);

    // Next-state for control, status and counter registers; CPU writes override hardware updates
    always_comb begin
        en_next     = en_reg;
        auto_next   = auto_reg;
        ie_next     = ie_reg;
        exp_next    = exp_reg;
        period_next = period_reg;
        count_next  = count_reg;
        presc_next  = presc_reg;

        // One-shot expiry stops the timer unless software rewrites EN this cycle
        if (expire && !auto_reg) begin
            en_next = 1'b0;
        end
        if (wr_ctrl && we[0]) begin
            en_next   = dw[CTRL_EN];
            auto_next = dw[CTRL_AUTO];
            ie_next   = dw[CTRL_IE];
        end

        // Set has priority over write-1-to-clear
        if (wr_stat && we[0] && dw[STAT_EXP]) begin
            exp_next = 1'b0;
        end
        if (expire) begin
            exp_next = 1'b1;
        end

        if (wr_period) begin
            period_next = lane_merge(period_reg, dw, wmask);
        end

        // Decrement or reload on tick; a COUNT write discards that update
        if (tick) begin
            if (count_reg != 32'd0) begin
                count_next = count_reg - 32'd1;
            end else if (auto_reg) begin
                count_next = period_reg;
            end
        end
        if (wr_count) begin
            count_next = lane_merge(count_reg, dw, wmask);
        end

        if (wr_presc) begin
            presc_next = presc_merge[PRESC_W-1:0];
        end
    end

    // Read mux; reserved words and unused bits read as zero
    always_comb begin
        rd_data = 32'd0;
        case (sel)
            REG_CTRL:   rd_data = {29'd0, ie_reg, auto_reg, en_reg};
            REG_STAT:   rd_data = {31'd0, exp_reg};
            REG_PERIOD: rd_data = period_reg;
            REG_COUNT:  rd_data = count_reg;
            REG_PRESC:  rd_data = presc_ext;
            REG_MTIME:  rd_data = mtime_reg;
            REG_RSV6:   rd_data = 32'd0;
            REG_RSV7:   rd_data = 32'd0;
            default:    rd_data = 32'd0;
        endcase
    end

    // State update, cycle counter, registered read data and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            en_reg     <= 1'b0;
            auto_reg   <= 1'b0;
            ie_reg     <= 1'b0;
            exp_reg    <= 1'b0;
            period_reg <= 32'hffff_ffff;
            count_reg  <= 32'd0;
            presc_reg  <= '0;
            mtime_reg  <= 32'd0;
            dr         <= 32'd0;
            irq        <= 1'b0;
        end else begin
            en_reg     <= en_next;
            auto_reg   <= auto_next;
            ie_reg     <= ie_next;
            exp_reg    <= exp_next;
            period_reg <= period_next;
            count_reg  <= count_next;
            presc_reg  <= presc_next;
            mtime_reg  <= mtime_reg + 32'd1;
            dr         <= (cs && re) ? rd_data : 32'd0;
            // Follows the registered flags, so it rises one cycle after EXP is set
            irq        <= exp_reg & ie_reg;
        end
    end

endmodule

// File: tb/tb_rv_timer.sv
// Directed testbench for rv_timer: register reset values, read latency,
// one-shot and auto-reload expiry, byte lanes, write collisions and reset.
module tb_rv_timer;
    import rv_timer_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  adr   = 5'd0;
    logic        cs    = 1'b0;
    logic        rdy   = 1'b1;
    logic [3:0]  we    = 4'd0;
    logic        re    = 1'b0;
    logic [31:0] dw    = 32'd0;
    logic [31:0] dr;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_timer #(
        .PRESC_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .cs    (cs),
        .rdy   (rdy),
        .we    (we),
        .re    (re),
        .dw    (dw),
        .dr    (dr),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp_v);
        chk(tag, {31'd0, irq}, {31'd0, exp_v});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One bus write, issued at a falling edge and captured at the next rising edge
    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
        cs = 1'b1; rdy = r; we = w; adr = a; dw = d; re = 1'b0;
        @(negedge clk);
        cs = 1'b0; we = 4'd0; rdy = 1'b1;
        $display("WR adr=%h data=%h we=%b rdy=%b", a, d, w, r);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w);
        bus_wr(a, d, w, 1'b1);
    endtask

    // One bus read; data is sampled one cycle after re
    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cs = 1'b1; re = 1'b1; we = 4'd0; adr = a;
        @(negedge clk);
        v = dr;
        cs = 1'b0; re = 1'b0;
        $display("RD adr=%h data=%h", a, v);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp_v);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp_v);
    endtask

    initial begin
        logic [31:0] v1, v2;

        // Reset and register reset values
        step(3);
        reset = 1'b0;
        chk_irq("rst_irq", 1'b0);
        chk("rst_dr", dr, 32'd0);
        rd_chk("rst_period", TMR_PERIOD, 32'hffff_ffff);
        chk("rd_latency_idle", dr, 32'hffff_ffff);
        step(1);
        chk("dr_zero_after_read", dr, 32'd0);
        rd_chk("rst_ctrl",  TMR_CTRL,  32'd0);
        rd_chk("rst_stat",  TMR_STAT,  32'd0);
        rd_chk("rst_count", TMR_COUNT, 32'd0);
        rd_chk("rst_presc", TMR_PRESC, 32'd0);
        rd(TMR_MTIME, v1);
        rd_chk("rst_rsv6",  TMR_RSV6,  32'd0);
        rd_chk("rst_rsv7",  TMR_RSV7,  32'd0);

        // One-shot: COUNT=5, PRESC=0 -> EXP 6 cycles after EN, irq one later
        wr(TMR_PRESC, 32'd0, 4'hF);
        wr(TMR_COUNT, 32'd5, 4'hF);
        wr(TMR_CTRL,  32'h5, 4'hF);
        step(6);
        chk_irq("os_irq_pre", 1'b0);
        step(1);
        chk_irq("os_irq_rise", 1'b1);
        rd_chk("os_ctrl_en_clr", TMR_CTRL,  32'h4);
        rd_chk("os_count_hold",  TMR_COUNT, 32'd0);
        rd_chk("os_stat_exp",    TMR_STAT,  32'd1);
        wr(TMR_STAT, 32'd1, 4'h1);
        chk_irq("os_irq_w1c_lag", 1'b1);
        step(1);
        chk_irq("os_irq_clr", 1'b0);

        // Auto-reload: PERIOD=3, PRESC=1 -> expiry every 8 cycles
        wr(TMR_PERIOD, 32'd3, 4'hF);
        wr(TMR_PRESC,  32'd1, 4'hF);
        wr(TMR_COUNT,  32'd3, 4'hF);
        wr(TMR_CTRL,   32'h7, 4'hF);
        step(8);
        for (int k = 1; k <= 4; k++) begin
            chk_irq("auto_pre", 1'b0);
            step(1);
            chk_irq("auto_rise", 1'b1);
            step(1);
            chk_irq("auto_sticky", 1'b1);
            wr(TMR_STAT, 32'd1, 4'h1);
            chk_irq("auto_w1c_lag", 1'b1);
            step(1);
            chk_irq("auto_clr", 1'b0);
            if (k < 4) step(4);
        end
        wr(TMR_CTRL, 32'h0, 4'hF);

        // Byte lanes, PRESC width, read-only and reserved words
        wr(TMR_COUNT, 32'd0, 4'hF);
        wr(TMR_COUNT, 32'haabb_ccdd, 4'b0101);
        rd_chk("lane_count", TMR_COUNT, 32'h00bb_00dd);
        wr(TMR_PRESC, 32'hffff_ffff, 4'hF);
        rd_chk("presc_width", TMR_PRESC, 32'h0000_ffff);
        wr(TMR_PRESC, 32'd0, 4'hF);
        rd(TMR_MTIME, v1);
        wr(TMR_MTIME, 32'h1234_5678, 4'hF);
        rd(TMR_MTIME, v2);
        chk("mtime_ro", v2, v1 + 32'd2);
        wr(TMR_RSV6, 32'hffff_ffff, 4'hF);
        rd_chk("rsv6_ignored", TMR_RSV6, 32'd0);

        // W1C in the expiry cycle: set wins
        wr(TMR_COUNT, 32'd2, 4'hF);
        wr(TMR_CTRL,  32'h1, 4'hF);
        step(2);
        wr(TMR_STAT, 32'd1, 4'h1);
        rd_chk("col_w1c_exp", TMR_STAT, 32'd1);
        rd_chk("col_os_en",   TMR_CTRL, 32'd0);
        wr(TMR_STAT, 32'd1, 4'b0010);
        rd_chk("w1c_wrong_lane", TMR_STAT, 32'd1);
        wr(TMR_STAT, 32'd0, 4'hF);
        rd_chk("w0_no_effect", TMR_STAT, 32'd1);
        wr(TMR_STAT, 32'd1, 4'h1);
        rd_chk("w1c_clear", TMR_STAT, 32'd0);

        // COUNT write in a tick cycle wins over the decrement
        wr(TMR_COUNT, 32'd20, 4'hF);
        wr(TMR_CTRL,  32'h1, 4'hF);
        wr(TMR_COUNT, 32'd9, 4'hF);
        rd_chk("col_count_wr", TMR_COUNT, 32'd9);
        wr(TMR_CTRL, 32'h0, 4'hF);

        // rdy=0 blocks the write
        bus_wr(TMR_PERIOD, 32'h55, 4'hF, 1'b0);
        rd_chk("rdy_block", TMR_PERIOD, 32'd3);

        // Reset mid-count with irq high
        wr(TMR_PERIOD, 32'd100, 4'hF);
        wr(TMR_COUNT,  32'd0, 4'hF);
        wr(TMR_CTRL,   32'h7, 4'hF);
        step(3);
        chk_irq("pre_rst_irq", 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        cs = 1'b1; re = 1'b1; we = 4'd0; adr = TMR_MTIME;
        chk_irq("mid_rst_irq", 1'b0);
        step(1);
        chk("mid_rst_mtime0", dr, 32'd0);
        step(1);
        chk("mid_rst_mtime1", dr, 32'd1);
        step(1);
        chk("mid_rst_mtime2", dr, 32'd2);
        cs = 1'b0; re = 1'b0;
        rd_chk("mid_rst_ctrl",   TMR_CTRL,   32'd0);
        rd_chk("mid_rst_stat",   TMR_STAT,   32'd0);
        rd_chk("mid_rst_period", TMR_PERIOD, 32'hffff_ffff);
        rd_chk("mid_rst_count",  TMR_COUNT,  32'd0);
        rd_chk("mid_rst_presc",  TMR_PRESC,  32'd0);
        chk_irq("mid_rst_irq_end", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
